// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MUL_BUSY  = 2'd2
    } state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int REG_AW      = 5;
    localparam int MUL_CNT_W   = 4;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    // A source operand conflicts only when the instruction actually reads it.
    function automatic logic addr_match(
        input logic              use_s,
        input logic [REG_AW-1:0] src_addr,
        input logic [REG_AW-1:0] dst_addr
    );
        return use_s && (src_addr == dst_addr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: the instruction in ID needs a register that the load
// in EX has not produced yet. Writes to the zero register never conflict.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rtaddr,
    input  logic [REG_AW-1:0] id_rsaddr,
    input  logic [REG_AW-1:0] id_rtaddr,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    output logic              hazard
);

    // Compare both ID source fields against the load destination.
    always_comb begin
        hazard = 1'b0;
        if (ex_memread && (ex_rtaddr != ZERO_REG)) begin
            hazard = addr_match(id_rs_use, id_rsaddr, ex_rtaddr) ||
                     addr_match(id_rt_use, id_rtaddr, ex_rtaddr);
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and a
// stall-cycle counter. Multi-cycle multiply occupancy is built only when
// HAZARD_CTRL_MUL_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] id_rsaddr_i,
    input  logic [REG_AW-1:0] id_rtaddr_i,
    input  logic              id_rs_use_i,
    input  logic              id_rt_use_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rtaddr_i,
    input  logic              id_branch_taken_i,
    input  logic              id_jump_i,
    input  logic              id_mul_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              mul_start_o,
    output logic              mul_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic             hazard_s;
    logic [CNT_W-1:0] stall_cnt_r;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread_i),
        .ex_rtaddr  (ex_rtaddr_i),
        .id_rsaddr  (id_rsaddr_i),
        .id_rtaddr  (id_rtaddr_i),
        .id_rs_use  (id_rs_use_i),
        .id_rt_use  (id_rt_use_i),
        .hazard     (hazard_s)
    );

`ifdef HAZARD_CTRL_MUL_EN
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LAT - 1);
    localparam logic [MUL_CNT_W-1:0] MUL_ONE  = {{(MUL_CNT_W-1){1'b0}}, 1'b1};

    logic [MUL_CNT_W-1:0] mul_cnt_r;

    // Sequencing FSM; the launch cycle counts as the first of MUL_LAT stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= RST_FLUSH;
            mul_cnt_r <= {MUL_CNT_W{1'b0}};
        end else begin
            case (state_r)
                RST_FLUSH: begin
                    state_r <= RUN;
                end
                RUN: begin
                    if (!hazard_s && id_mul_i) begin
                        state_r   <= MUL_BUSY;
                        mul_cnt_r <= MUL_LOAD;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt_r != {MUL_CNT_W{1'b0}}) begin
                        mul_cnt_r <= mul_cnt_r - MUL_ONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r   <= RST_FLUSH;
                    mul_cnt_r <= {MUL_CNT_W{1'b0}};
                end
            endcase
        end
    end
`else
    logic unused_mul_s;
    localparam int UNUSED_MUL_LAT = MUL_LAT;
    assign unused_mul_s = id_mul_i;

    // Sequencing FSM without multiply support.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= RST_FLUSH;
        end else begin
            case (state_r)
                RST_FLUSH: state_r <= RUN;
                RUN:       state_r <= RUN;
                default:   state_r <= RST_FLUSH;
            endcase
        end
    end
`endif

    // Pipeline control decode; a hazard outranks everything so a branch waits.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        mul_start_o    = 1'b0;
        mul_busy_o     = 1'b0;
        case (state_r)
            RST_FLUSH: begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end
            RUN: begin
                if (hazard_s) begin
                    id_ex_bubble_o = 1'b1;
`ifdef HAZARD_CTRL_MUL_EN
                end else if (id_mul_i) begin
                    id_ex_bubble_o = 1'b1;
                    mul_start_o    = 1'b1;
`endif
                end else if (id_branch_taken_i || id_jump_i) begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                    if_id_flush_o = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            end
`ifdef HAZARD_CTRL_MUL_EN
            MUL_BUSY: begin
                mul_busy_o = 1'b1;
                if (mul_cnt_r != {MUL_CNT_W{1'b0}}) begin
                    id_ex_bubble_o = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            end
`endif
            default: begin
                if_id_flush_o  = 1'b1;
                id_ex_bubble_o = 1'b1;
            end
        endcase
    end

    // Saturating count of cycles in which the PC was held outside reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != RST_FLUSH) && !pc_write_o && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: each vector queues its expected
// output bundle; a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [4:0]       id_rsaddr_i, id_rtaddr_i, ex_rtaddr_i;
    logic             id_rs_use_i, id_rt_use_i, ex_memread_i;
    logic             id_branch_taken_i, id_jump_i, id_mul_i;
    logic             pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o;
    logic             mul_start_o, mul_busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    typedef struct packed {
        logic             pc;
        logic             ifw;
        logic             fl;
        logic             bub;
        logic             ms;
        logic             mb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .id_rsaddr_i       (id_rsaddr_i),
        .id_rtaddr_i       (id_rtaddr_i),
        .id_rs_use_i       (id_rs_use_i),
        .id_rt_use_i       (id_rt_use_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rtaddr_i       (ex_rtaddr_i),
        .id_branch_taken_i (id_branch_taken_i),
        .id_jump_i         (id_jump_i),
        .id_mul_i          (id_mul_i),
        .pc_write_o        (pc_write_o),
        .if_id_write_o     (if_id_write_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_bubble_o    (id_ex_bubble_o),
        .mul_start_o       (mul_start_o),
        .mul_busy_o        (mul_busy_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    function automatic exp_t mk(input logic pc, input logic ifw, input logic fl,
                                input logic bub, input logic ms, input logic mb,
                                input logic [CNT_W-1:0] c);
        return exp_t'({pc, ifw, fl, bub, ms, mb, c});
    endfunction

    function automatic exp_t run_ok(input logic [CNT_W-1:0] c);
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction

    function automatic exp_t stall(input logic [CNT_W-1:0] c);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c);
    endfunction

    function automatic exp_t flush(input logic [CNT_W-1:0] c);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c);
    endfunction

    function automatic exp_t rst_e();
        return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    endfunction

    // One cycle of stimulus, applied just after the rising edge.
    task automatic vec(input logic rst, input logic memrd, input logic [4:0] exrt,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic br, input logic jmp, input logic mul,
                       input exp_t e, input string tag);
        @(posedge clk_i);
        #1;
        rst_n_i           = rst;
        ex_memread_i      = memrd;
        ex_rtaddr_i       = exrt;
        id_rsaddr_i       = rs;
        id_rs_use_i       = rsu;
        id_rtaddr_i       = rt;
        id_rt_use_i       = rtu;
        id_branch_taken_i = br;
        id_jump_i         = jmp;
        id_mul_i          = mul;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input exp_t e, input string tag);
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e, tag);
    endtask

    // Monitor: compare the presented output bundle against the oldest expectation.
    initial begin
        exp_t  e;
        exp_t  got;
        string t;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = mk(pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
                         mul_start_o, mul_busy_o, stall_cnt_o);
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got pc=%0b ifw=%0b flush=%0b bubble=%0b start=%0b busy=%0b cnt=%0d, required pc=%0b ifw=%0b flush=%0b bubble=%0b start=%0b busy=%0b cnt=%0d",
                             t, got.pc, got.ifw, got.fl, got.bub, got.ms, got.mb, got.cnt,
                             e.pc, e.ifw, e.fl, e.bub, e.ms, e.mb, e.cnt);
                end
            end
        end
    end

    initial begin
        rst_n_i = 1'b0;
        ex_memread_i = 1'b0; ex_rtaddr_i = 5'd0;
        id_rsaddr_i = 5'd0; id_rs_use_i = 1'b0;
        id_rtaddr_i = 5'd0; id_rt_use_i = 1'b0;
        id_branch_taken_i = 1'b0; id_jump_i = 1'b0; id_mul_i = 1'b0;

        for (int i = 0; i < 3; i++) begin
            vec(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rst_e(), "reset_hold");
        end
        idle(rst_e(), "release_edge");
        idle(run_ok(4'd0), "run_idle");

        vec(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, stall(4'd0), "load_use_rs");
        idle(run_ok(4'd1), "after_load");
        vec(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, run_ok(4'd1), "zero_reg");
        vec(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, stall(4'd1), "load_use_rt");
        vec(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, run_ok(4'd2), "no_use");
        vec(1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, run_ok(4'd2), "no_load");

        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, flush(4'd2), "branch");
        vec(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stall(4'd2), "branch_hazard");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, flush(4'd3), "branch_retry");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, flush(4'd3), "jump");

`ifdef HAZARD_CTRL_MUL_EN
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3), "mul_start");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
            mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4), "mul_busy1");
        vec(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5), "mul_busy2");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6), "mul_busy3");
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
            mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7), "mul_release");
        idle(run_ok(4'd7), "after_mul");
        vec(1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, stall(4'd7), "mul_hazard");
        idle(run_ok(4'd8), "mul_hazard_no_busy");

        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
            mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8), "mul2_start");
        idle(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9), "mul2_busy");
        vec(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rst_e(), "reset_mid_mul");
        vec(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rst_e(), "reset_mid_mul_hold");
        idle(rst_e(), "release2_edge");
        idle(run_ok(4'd0), "no_spurious_release");
        idle(run_ok(4'd0), "no_spurious_release2");
`else
        vec(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, run_ok(4'd3), "mul_ignored");
        idle(run_ok(4'd3), "mul_ignored_next");
        vec(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rst_e(), "reset2");
        idle(rst_e(), "release2_edge");
        idle(run_ok(4'd0), "run_idle2");
`endif

        for (int i = 0; i < 20; i++) begin
            vec(1'b1, 1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                stall(CNT_W'((i > 15) ? 15 : i)), "sat_stall");
        end
        idle(run_ok(4'd15), "sat_hold");
        vec(1'b1, 1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, stall(4'd15), "sat_stall_more");
        idle(run_ok(4'd15), "sat_hold2");

        for (int k = 0; (k < 20) && (exp_q.size() > 0); k++) begin
            @(posedge clk_i);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
